// File: rtl/execute_eflags_unit.sv
// Execute-stage EFLAGS unit: one-deep pending slot for flag-producing micro-ops,
// the architectural EFLAGS register, and x86 condition-code evaluation.
module execute_eflags_unit #(
  parameter int                DATA_W     = 64,
  parameter int                FLAG_W     = 64,
  parameter logic [FLAG_W-1:0] EFLAGS_RST = 'h2,
  parameter logic [FLAG_W-1:0] WR_MASK    = 'h0CD5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [1:0]        bit_mode,
  input  logic [DATA_W-1:0] s,
  input  logic [DATA_W-1:0] t,
  input  logic              hold,
  input  logic              flush,
  output logic [FLAG_W-1:0] eflags,
  output logic              flags_busy,
  output logic              commit_valid,
  input  logic [3:0]        cond,
  output logic              cond_true
);

  localparam logic [2:0] OP_CMP  = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_TEST = 3'd2;
  localparam logic [2:0] OP_INC  = 3'd3;
  localparam logic [2:0] OP_DEC  = 3'd4;
  localparam logic [2:0] OP_WRFL = 3'd5;
  localparam logic [2:0] OP_CLC  = 3'd6;
  localparam logic [2:0] OP_STC  = 3'd7;

  localparam int CF_B = 0;
  localparam int RS_B = 1;
  localparam int PF_B = 2;
  localparam int AF_B = 4;
  localparam int ZF_B = 6;
  localparam int SF_B = 7;
  localparam int OF_B = 11;

  function automatic logic [63:0] width_mask(input logic [1:0] m);
    case (m)
      2'd0:    width_mask = 64'h0000_0000_0000_00FF;
      2'd1:    width_mask = 64'h0000_0000_0000_FFFF;
      2'd2:    width_mask = 64'h0000_0000_FFFF_FFFF;
      default: width_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  function automatic logic sign_of(input logic [63:0] v, input logic [1:0] m);
    case (m)
      2'd0:    sign_of = v[7];
      2'd1:    sign_of = v[15];
      2'd2:    sign_of = v[31];
      default: sign_of = v[63];
    endcase
  endfunction

  function automatic logic even_parity(input logic [7:0] v);
    even_parity = ~^v;
  endfunction

  logic              vld_p0;
  logic [2:0]        op_p0;
  logic [1:0]        mode_p0;
  logic [DATA_W-1:0] s_p0;
  logic [DATA_W-1:0] t_p0;

  logic              commit;
  logic              accept;

  assign commit     = vld_p0 && !hold && !flush;
  assign in_ready   = !flush && (!vld_p0 || commit);
  assign accept     = in_valid && in_ready;
  assign flags_busy = vld_p0;

  // Stage p0: pending slot capture (data unreset, valid under reset)
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0   <= op;
      mode_p0 <= bit_mode;
      s_p0    <= s;
      t_p0    <= t;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p0 <= 1'b0;
    end else if (flush) begin
      vld_p0 <= 1'b0;
    end else if (accept) begin
      vld_p0 <= 1'b1;
    end else if (commit) begin
      vld_p0 <= 1'b0;
    end
  end

  logic [63:0]       msk;
  logic [63:0]       sw;
  logic [63:0]       tw;
  logic [64:0]       sum_w;
  logic [63:0]       res;
  logic [63:0]       nib_x;
  logic              is_sub;
  logic              carry;
  logic              aux;
  logic              ovf;
  logic              s_sgn;
  logic              t_sgn;
  logic              r_sgn;
  logic [FLAG_W-1:0] s_f;
  logic [FLAG_W-1:0] next_flags;

  // Carry/borrow out of bit W-1 is bit W of the unmasked 65-bit sum, read as
  // the sign position of the sum shifted down by one.
  always_comb begin
    msk    = width_mask(mode_p0);
    sw     = s_p0[63:0] & msk;
    tw     = (op_p0 == OP_INC || op_p0 == OP_DEC) ? 64'd1 : (t_p0[63:0] & msk);
    is_sub = (op_p0 == OP_CMP) || (op_p0 == OP_DEC);
    sum_w  = is_sub ? ({1'b0, sw} - {1'b0, tw}) : ({1'b0, sw} + {1'b0, tw});
    res    = (op_p0 == OP_TEST) ? (sw & tw) : (sum_w[63:0] & msk);
    nib_x  = sw ^ tw ^ sum_w[63:0];
    carry  = sign_of(sum_w[64:1], mode_p0);
    aux    = nib_x[4];
    s_sgn  = sign_of(sw, mode_p0);
    t_sgn  = sign_of(tw, mode_p0);
    r_sgn  = sign_of(res, mode_p0);
    ovf    = is_sub ? ((s_sgn != t_sgn) && (r_sgn != s_sgn))
                    : ((s_sgn == t_sgn) && (r_sgn != s_sgn));
    s_f    = FLAG_W'(s_p0);
  end

  always_comb begin
    next_flags = eflags;
    case (op_p0)
      OP_CMP, OP_ADD, OP_INC, OP_DEC: begin
        next_flags[OF_B] = ovf;
        next_flags[SF_B] = r_sgn;
        next_flags[ZF_B] = (res == 64'd0);
        next_flags[AF_B] = aux;
        next_flags[PF_B] = even_parity(res[7:0]);
        if (op_p0 == OP_CMP || op_p0 == OP_ADD) begin
          next_flags[CF_B] = carry;
        end
      end
      OP_TEST: begin
        next_flags[OF_B] = 1'b0;
        next_flags[SF_B] = r_sgn;
        next_flags[ZF_B] = (res == 64'd0);
        next_flags[AF_B] = 1'b0;
        next_flags[PF_B] = even_parity(res[7:0]);
        next_flags[CF_B] = 1'b0;
      end
      OP_WRFL: next_flags = (s_f & WR_MASK) | (eflags & ~WR_MASK);
      OP_CLC:  next_flags[CF_B] = 1'b0;
      OP_STC:  next_flags[CF_B] = 1'b1;
      default: next_flags = eflags;
    endcase
    next_flags[RS_B] = 1'b1;
  end

  // Stage p1: architectural EFLAGS and commit pulse
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      eflags       <= EFLAGS_RST;
      commit_valid <= 1'b0;
    end else begin
      commit_valid <= commit;
      if (commit) begin
        eflags <= next_flags;
      end
    end
  end

  logic cc_base;

  always_comb begin
    case (cond[3:1])
      3'd0:    cc_base = eflags[OF_B];
      3'd1:    cc_base = eflags[CF_B];
      3'd2:    cc_base = eflags[ZF_B];
      3'd3:    cc_base = eflags[CF_B] | eflags[ZF_B];
      3'd4:    cc_base = eflags[SF_B];
      3'd5:    cc_base = eflags[PF_B];
      3'd6:    cc_base = eflags[SF_B] ^ eflags[OF_B];
      default: cc_base = eflags[ZF_B] | (eflags[SF_B] ^ eflags[OF_B]);
    endcase
    cond_true = cc_base ^ cond[0];
  end

endmodule
